dfb_spi_master: RTL and testbench

Parametrised SPI master peripheral for the DFB accelerator CPLD. It is the successor to the fixed single-CS, mode-0, MSB-first SPI register pair. It adds the following:
- selectable SPI mode (CPOL/CPHA)
- LSB-first option
- programmable SCK divider
- NUM_CS chip selects
- overrun detection
- optional completion interrupt

It sits behind the board's register decode (F1DFBx window) and is clocked from the oscillator domain.

---
 rtl/dfb_spi_master.sv | 235 +++++++++++++++++++++++
 tb/tb_dfb_spi_master.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dfb_spi_master.sv
// dfb_spi_master -- register-mapped SPI master for the DFB accelerator CPLD.
//
// One 8-bit transfer per DATA write. SPI mode (CPOL/CPHA), bit order and the
// SCK half-period (DIV+1 CLKOSC cycles) are programmable. Chip selects are
// driven by software only, through CSEL.
//
// Optional feature macro: DFB_SPI_IRQ_EN adds the IRQ_N port and CTRL[3] (IE).
//
// Ports:
//   CLKOSC     system clock; all state changes on the rising edge
//   RST        asynchronous reset, active low
//   REG_CS_N   register access strobe, active low; acted on at its falling edge
//   REG_RW     1 = read, 0 = write
//   REG_ADDR   register index: 0 ID, 1 STATUS, 2 CTRL, 3 DIV, 4 DATA, 5 CSEL
//   REG_WDATA  write data
//   REG_RDATA  read data, combinational from REG_ADDR (8'h00 when unmapped)
//   SPI_SCK    serial clock
//   SPI_MOSI   serial data out
//   SPI_MISO   serial data in
//   SPI_CS_N   chip selects, active low
//   IRQ_N      completion interrupt, active low (DFB_SPI_IRQ_EN builds only)
module dfb_spi_master #(
  parameter int NUM_CS = 2,
  parameter int DIV_W  = 8
) (
  input  logic              CLKOSC,
  input  logic              RST,
  input  logic              REG_CS_N,
  input  logic              REG_RW,
  input  logic [2:0]        REG_ADDR,
  input  logic [7:0]        REG_WDATA,
  output logic [7:0]        REG_RDATA,
  output logic              SPI_SCK,
  output logic              SPI_MOSI,
  input  logic              SPI_MISO,
  output logic [NUM_CS-1:0] SPI_CS_N
`ifdef DFB_SPI_IRQ_EN
  ,
  output logic              IRQ_N
`endif
);

  localparam logic [2:0] ADDR_ID     = 3'd0;
  localparam logic [2:0] ADDR_STATUS = 3'd1;
  localparam logic [2:0] ADDR_CTRL   = 3'd2;
  localparam logic [2:0] ADDR_DIV    = 3'd3;
  localparam logic [2:0] ADDR_DATA   = 3'd4;
  localparam logic [2:0] ADDR_CSEL   = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LEAD,
    ST_TRAIL,
    ST_FINISH
  } state_t;

  state_t            state_reg;
  logic              cs_n_prev_reg;
  logic              cpha_reg;
  logic              cpol_reg;
  logic              lsbf_reg;
  logic              ie_bit;
  logic [DIV_W-1:0]  div_reg;
  logic [DIV_W-1:0]  cnt_reg;
  logic [2:0]        bit_cnt_reg;
  logic [7:0]        shift_reg;
  logic [7:0]        rx_reg;
  logic              busy_reg;
  logic              done_reg;
  logic              ovr_reg;
  logic [NUM_CS-1:0] csel_reg;
  logic              sck_reg;
  logic              mosi_reg;

  logic              access;
  logic              wr_en;
  logic              rd_en;
  logic              data_wr;
  logic              cfg_wr_ok;
  logic [7:0]        shift_in;

`ifdef DFB_SPI_IRQ_EN
  logic ie_reg;
  logic irq_n_reg;
  assign ie_bit = ie_reg;
  assign IRQ_N  = irq_n_reg;
`else
  assign ie_bit = 1'b0;
`endif

  // An access is taken only on the first edge of a low REG_CS_N period.
  assign access    = ~REG_CS_N & cs_n_prev_reg;
  assign wr_en     = access & ~REG_RW;
  assign rd_en     = access & REG_RW;
  assign data_wr   = wr_en && (REG_ADDR == ADDR_DATA);
  // CTRL/DIV are frozen for the whole transfer, FINISH included.
  assign cfg_wr_ok = wr_en && !busy_reg;

  // Shift register after one sample: the outgoing bit leaves from the end
  // selected by LSBF and MISO enters from the opposite end, so RX ends up in
  // the same bit order as TX.
  assign shift_in = lsbf_reg ? {SPI_MISO, shift_reg[7:1]} : {shift_reg[6:0], SPI_MISO};

  function automatic logic out_bit(input logic [7:0] v, input logic lsbf);
    return lsbf ? v[0] : v[7];
  endfunction

  assign SPI_SCK  = sck_reg;
  assign SPI_MOSI = mosi_reg;
  assign SPI_CS_N = ~csel_reg;

  always_comb begin
    REG_RDATA = 8'h00;
    case (REG_ADDR)
      ADDR_ID:     REG_RDATA = 8'h02;
      ADDR_STATUS: REG_RDATA = {busy_reg, done_reg, ovr_reg, 5'b00000};
      ADDR_CTRL:   REG_RDATA = {4'b0000, ie_bit, lsbf_reg, cpol_reg, cpha_reg};
      ADDR_DIV:    REG_RDATA[DIV_W-1:0] = div_reg;
      ADDR_DATA:   REG_RDATA = rx_reg;
      ADDR_CSEL:   REG_RDATA[NUM_CS-1:0] = csel_reg;
      default:     REG_RDATA = 8'h00;
    endcase
  end

  always_ff @(posedge CLKOSC or negedge RST) begin
    if (!RST) begin
      state_reg     <= ST_IDLE;
      cs_n_prev_reg <= 1'b1;
      cpha_reg      <= 1'b0;
      cpol_reg      <= 1'b0;
      lsbf_reg      <= 1'b0;
      div_reg       <= '1;
      cnt_reg       <= '0;
      bit_cnt_reg   <= 3'd0;
      shift_reg     <= 8'hFF;
      rx_reg        <= 8'hFF;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      ovr_reg       <= 1'b0;
      csel_reg      <= '0;
      sck_reg       <= 1'b0;
      mosi_reg      <= 1'b1;
`ifdef DFB_SPI_IRQ_EN
      ie_reg        <= 1'b0;
      irq_n_reg     <= 1'b1;
`endif
    end else begin
      cs_n_prev_reg <= REG_CS_N;

      if (cfg_wr_ok && REG_ADDR == ADDR_CTRL) begin
        cpha_reg <= REG_WDATA[0];
        cpol_reg <= REG_WDATA[1];
        lsbf_reg <= REG_WDATA[2];
`ifdef DFB_SPI_IRQ_EN
        ie_reg   <= REG_WDATA[3];
`endif
      end
      if (cfg_wr_ok && REG_ADDR == ADDR_DIV)
        div_reg <= REG_WDATA[DIV_W-1:0];
      if (wr_en && REG_ADDR == ADDR_CSEL)
        csel_reg <= REG_WDATA[NUM_CS-1:0];

      if (rd_en && REG_ADDR == ADDR_STATUS)
        ovr_reg <= 1'b0;
      if (data_wr && busy_reg)
        ovr_reg <= 1'b1;
      if (rd_en && REG_ADDR == ADDR_DATA)
        done_reg <= 1'b0;

`ifdef DFB_SPI_IRQ_EN
      irq_n_reg <= ~(done_reg & ie_reg);
`endif

      case (state_reg)
        ST_IDLE: begin
          // Idle SCK tracks CPOL, including a CPOL change written this cycle.
          sck_reg <= (cfg_wr_ok && REG_ADDR == ADDR_CTRL) ? REG_WDATA[1] : cpol_reg;
          if (data_wr) begin
            shift_reg   <= REG_WDATA;
            mosi_reg    <= out_bit(REG_WDATA, lsbf_reg);
            done_reg    <= 1'b0;
            busy_reg    <= 1'b1;
            cnt_reg     <= div_reg;
            bit_cnt_reg <= 3'd0;
            sck_reg     <= cpol_reg ^ cpha_reg;
            state_reg   <= ST_LEAD;
          end
        end
        ST_LEAD: begin
          if (cnt_reg == '0) begin
            if (!cpha_reg)
              shift_reg <= shift_in;
            cnt_reg   <= div_reg;
            sck_reg   <= ~(cpol_reg ^ cpha_reg);
            state_reg <= ST_TRAIL;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        ST_TRAIL: begin
          if (cnt_reg == '0) begin
            if (cpha_reg)
              shift_reg <= shift_in;
            cnt_reg <= div_reg;
            if (bit_cnt_reg == 3'd7) begin
              // MOSI keeps the last bit; SCK goes straight back to idle.
              sck_reg   <= cpol_reg;
              state_reg <= ST_FINISH;
            end else begin
              // CPHA=1 samples on this same edge, so the next bit comes from
              // the freshly shifted value.
              mosi_reg    <= out_bit(cpha_reg ? shift_in : shift_reg, lsbf_reg);
              bit_cnt_reg <= bit_cnt_reg + 3'd1;
              sck_reg     <= cpol_reg ^ cpha_reg;
              state_reg   <= ST_LEAD;
            end
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        ST_FINISH: begin
          // Placed after the DATA-read clear so a coincident read cannot
          // cancel DONE.
          rx_reg    <= shift_reg;
          done_reg  <= 1'b1;
          busy_reg  <= 1'b0;
          sck_reg   <= cpol_reg;
          state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dfb_spi_master.sv
// tb_dfb_spi_master -- self-checking bench for dfb_spi_master.
// A behavioural SPI slave reacts to SCK edges: it captures MOSI into a byte and
// presents its own byte on MISO, so the expected RX is simply the slave byte
// (or the TX byte in loopback) and the slave's captured byte must equal TX.
// Build with +define+DFB_SPI_IRQ_EN to exercise the interrupt output.
module tb_dfb_spi_master;
  localparam int NUM_CS = 2;
  localparam int DIV_W  = 8;

  localparam logic [2:0] A_ID     = 3'd0;
  localparam logic [2:0] A_STATUS = 3'd1;
  localparam logic [2:0] A_CTRL   = 3'd2;
  localparam logic [2:0] A_DIV    = 3'd3;
  localparam logic [2:0] A_DATA   = 3'd4;
  localparam logic [2:0] A_CSEL   = 3'd5;

  logic              CLKOSC    = 1'b0;
  logic              RST       = 1'b0;
  logic              REG_CS_N  = 1'b1;
  logic              REG_RW    = 1'b1;
  logic [2:0]        REG_ADDR  = 3'd0;
  logic [7:0]        REG_WDATA = 8'h00;
  logic [7:0]        REG_RDATA;
  logic              SPI_SCK;
  logic              SPI_MOSI;
  logic              SPI_MISO;
  logic [NUM_CS-1:0] SPI_CS_N;
`ifdef DFB_SPI_IRQ_EN
  logic              IRQ_N;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Slave model state
  logic       s_active = 1'b0;
  logic       s_cpol   = 1'b0;
  logic       s_cpha   = 1'b0;
  logic       s_lsbf   = 1'b0;
  logic       s_loop   = 1'b0;
  logic [7:0] s_tx     = 8'h00;
  logic [7:0] s_rx     = 8'h00;
  logic       s_miso   = 1'b0;
  int         s_idx    = 0;
  int         lead_cnt = 0;
  int         trail_cnt = 0;

  assign SPI_MISO = s_loop ? SPI_MOSI : s_miso;

  dfb_spi_master #(.NUM_CS(NUM_CS), .DIV_W(DIV_W)) dut (
    .CLKOSC    (CLKOSC),
    .RST       (RST),
    .REG_CS_N  (REG_CS_N),
    .REG_RW    (REG_RW),
    .REG_ADDR  (REG_ADDR),
    .REG_WDATA (REG_WDATA),
    .REG_RDATA (REG_RDATA),
    .SPI_SCK   (SPI_SCK),
    .SPI_MOSI  (SPI_MOSI),
    .SPI_MISO  (SPI_MISO),
    .SPI_CS_N  (SPI_CS_N)
`ifdef DFB_SPI_IRQ_EN
    ,
    .IRQ_N     (IRQ_N)
`endif
  );

  always #5 CLKOSC = ~CLKOSC;
  always @(posedge CLKOSC) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic sbit(input logic [7:0] v, input int i, input logic lsbf);
    if (i < 0 || i > 7) return 1'b0;
    return lsbf ? v[i] : v[7-i];
  endfunction

  // SPI slave: sample on one SCK edge, launch the next bit on the other.
  always @(SPI_SCK) begin
    if (s_active) begin
      if (SPI_SCK !== s_cpol) begin
        lead_cnt = lead_cnt + 1;
        if (!s_cpha) begin
          if (s_idx < 8) s_rx[s_lsbf ? s_idx : 7 - s_idx] = SPI_MOSI;
        end else begin
          s_miso = sbit(s_tx, s_idx, s_lsbf);
        end
      end else begin
        trail_cnt = trail_cnt + 1;
        if (!s_cpha) begin
          s_idx  = s_idx + 1;
          s_miso = sbit(s_tx, s_idx, s_lsbf);
        end else begin
          if (s_idx < 8) s_rx[s_lsbf ? s_idx : 7 - s_idx] = SPI_MOSI;
          s_idx = s_idx + 1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      failures = failures + 1;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // All bus tasks are entered and left on a falling clock edge.
  task automatic reg_wr(input logic [2:0] a, input logic [7:0] d);
    REG_ADDR = a; REG_WDATA = d; REG_RW = 1'b0; REG_CS_N = 1'b0;
    @(negedge CLKOSC);
    REG_CS_N = 1'b1;
    @(negedge CLKOSC);
  endtask

  task automatic reg_rd(input logic [2:0] a, output logic [7:0] d);
    REG_ADDR = a; REG_RW = 1'b1; REG_CS_N = 1'b0;
    #1 d = REG_RDATA;
    @(negedge CLKOSC);
    REG_CS_N = 1'b1;
    @(negedge CLKOSC);
  endtask

  // Advance so that the next bus access is taken on rising edge number 'edge_num'.
  task automatic goto(input int edge_num);
    while (cyc < edge_num - 1) @(negedge CLKOSC);
  endtask

  task automatic slave_setup(input logic cpol, input logic cpha, input logic lsbf,
                             input logic [7:0] slv, input logic loop);
    s_cpol = cpol; s_cpha = cpha; s_lsbf = lsbf; s_tx = slv; s_loop = loop;
    s_idx = 0; s_rx = 8'h00; lead_cnt = 0; trail_cnt = 0;
    s_miso = sbit(slv, 0, lsbf);
    s_active = 1'b1;
  endtask

  // DATA write; returns the rising-edge number on which it was taken.
  task automatic kick(input logic cpol, input logic cpha, input logic [7:0] tx, output int t0);
    logic exp_sck;
    REG_ADDR = A_DATA; REG_WDATA = tx; REG_RW = 1'b0; REG_CS_N = 1'b0;
    @(negedge CLKOSC);
    t0 = cyc;
    exp_sck = cpha ? ~cpol : cpol;
    chk("start_sck", SPI_SCK, exp_sck);
    REG_CS_N = 1'b1;
    @(negedge CLKOSC);
  endtask

  task automatic run_xfer(input logic cpol, input logic cpha, input logic lsbf,
                          input logic [7:0] dv, input logic [7:0] tx, input logic [7:0] slv,
                          input logic loop, input logic mid_wr);
    logic [7:0] d;
    logic [7:0] exp_rx;
    int t0;
    int fin;
    reg_wr(A_CTRL, {5'b00000, lsbf, cpol, cpha});
    reg_wr(A_DIV, dv);
    chk("idle_sck", SPI_SCK, cpol);
    slave_setup(cpol, cpha, lsbf, slv, loop);
    kick(cpol, cpha, tx, t0);
    if (mid_wr) begin
      goto(t0 + 6);
      reg_wr(A_DATA, 8'h11);
      reg_wr(A_CTRL, 8'h07);
      reg_wr(A_DIV, 8'h00);
    end
    // Busy spans 16*(DIV+1)+1 cycles: the last busy cycle is the one ending
    // on edge t0+16*(DIV+1)+1, so a read taken there still sees BUSY.
    fin = t0 + 16 * (int'(dv) + 1) + 1;
    goto(fin);
    reg_rd(A_STATUS, d);
    chk("finish_status", d, {1'b1, 1'b0, mid_wr, 5'b00000});
    reg_rd(A_STATUS, d);
    chk("done_status", d, 8'h40);
    exp_rx = loop ? tx : slv;
    reg_rd(A_DATA, d);
    chk("rx", d, exp_rx);
    reg_rd(A_STATUS, d);
    chk("done_clear", d, 8'h00);
    chk("slave_rx", s_rx, tx);
    chk("lead_edges", lead_cnt, 8);
    chk("trail_edges", trail_cnt, 8);
    chk("end_sck", SPI_SCK, cpol);
    if (mid_wr) begin
      reg_rd(A_CTRL, d);
      chk("ctrl_locked", d, {5'b00000, lsbf, cpol, cpha});
      reg_rd(A_DIV, d);
      chk("div_locked", d, dv);
    end
    s_active = 1'b0;
    $display("xfer cpol=%0d cpha=%0d lsbf=%0d div=%0d tx=%02h slave=%02h rx_exp=%02h slave_got=%02h",
             cpol, cpha, lsbf, dv, tx, slv, exp_rx, s_rx);
  endtask

  initial begin
    logic [7:0] d;
    logic [7:0] exp_tab [8];
    int t0;

    exp_tab = '{8'h02, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00};
    repeat (3) @(negedge CLKOSC);
    RST = 1'b1;
    @(negedge CLKOSC);

    // Reset state
    chk("rst_sck", SPI_SCK, 1'b0);
    chk("rst_mosi", SPI_MOSI, 1'b1);
    chk("rst_cs_n", SPI_CS_N, 2'b11);
`ifdef DFB_SPI_IRQ_EN
    chk("rst_irq_n", IRQ_N, 1'b1);
`endif
    for (int a = 0; a < 8; a++) begin
      reg_rd(3'(a), d);
      chk($sformatf("rst_reg%0d", a), d, exp_tab[a]);
    end
    reg_wr(A_ID, 8'h55);
    reg_rd(A_ID, d);
    chk("id_ro", d, 8'h02);

    // Mode 0, DIV 0, loopback A5
    reg_wr(A_CSEL, 8'h01);
    chk("cs_sel", SPI_CS_N, 2'b10);
    reg_rd(A_CSEL, d);
    chk("csel_rb", d, 8'h01);
    run_xfer(1'b0, 1'b0, 1'b0, 8'd0, 8'hA5, 8'h00, 1'b1, 1'b0);

    // Mode 3, LSB first, DIV 3, slave pattern 3C
    run_xfer(1'b1, 1'b1, 1'b1, 8'd3, 8'h96, 8'h3C, 1'b0, 1'b0);

    // Overrun: second DATA write (plus CTRL/DIV writes) during a transfer
    run_xfer(1'b0, 1'b1, 1'b0, 8'd2, 8'hC3, 8'h5A, 1'b0, 1'b1);

    // Reset in the middle of bit 4
    reg_wr(A_CTRL, 8'h00);
    reg_wr(A_DIV, 8'd1);
    slave_setup(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    kick(1'b0, 1'b0, 8'h0F, t0);
    goto(t0 + 17);
    s_active = 1'b0;
    #2 RST = 1'b0;
    #1;
    chk("arst_sck", SPI_SCK, 1'b0);
    chk("arst_mosi", SPI_MOSI, 1'b1);
    chk("arst_cs_n", SPI_CS_N, 2'b11);
    @(negedge CLKOSC);
    @(negedge CLKOSC);
    RST = 1'b1;
    @(negedge CLKOSC);
    reg_rd(A_STATUS, d);
    chk("arst_status", d, 8'h00);
    reg_rd(A_DATA, d);
    chk("arst_rx", d, 8'hFF);
    reg_rd(A_DIV, d);
    chk("arst_div", d, 8'hFF);
    $display("async reset mid-transfer done");
    run_xfer(1'b0, 1'b0, 1'b0, 8'd1, 8'h3A, 8'hE7, 1'b0, 1'b0);

    // CTRL IE bit
`ifdef DFB_SPI_IRQ_EN
    reg_wr(A_CTRL, 8'h08);
    reg_rd(A_CTRL, d);
    chk("ctrl_ie", d, 8'h08);
    reg_wr(A_DIV, 8'd0);
    slave_setup(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    kick(1'b0, 1'b0, 8'h81, t0);
    while (cyc < t0 + 17) @(negedge CLKOSC);
    chk("irq_before", IRQ_N, 1'b1);
    @(negedge CLKOSC);
    chk("irq_assert", IRQ_N, 1'b0);
    reg_rd(A_DATA, d);
    chk("irq_release", IRQ_N, 1'b1);
    s_active = 1'b0;
    reg_wr(A_CTRL, 8'h00);
    $display("irq transfer done");
`else
    reg_wr(A_CTRL, 8'h08);
    reg_rd(A_CTRL, d);
    chk("ctrl_no_ie", d, 8'h00);
`endif

    // Randomised transfers
    for (int n = 0; n < 16; n++) begin
      run_xfer(1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)),
               8'($urandom_range(3)), 8'($urandom), 8'($urandom), 1'b0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
